// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready request/response to APB4 initiator bridge
//
// Purpose: accepts one request at a time from an upstream valid/ready bus,
// runs it as an APB4 SETUP/ACCESS transfer and returns the result on a
// valid/ready response channel. A PREADY timeout aborts transfers to a hung
// slave and reports them as errors.
//
// Ports:
//   clock, reset                 clock and synchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_addr/write/wdata/wstrb/prot  request fields, latched at acceptance
//   resp_valid/resp_ready        response handshake
//   resp_rdata/err/timeout       response fields, held until accepted
//   out_psel/penable/pprot/paddr/pwrite/pwdata/pstrb  APB request side
//   out_pready/pslverr/prdata    APB completion side
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    input  logic [2:0]        req_prot,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              resp_timeout,
    output logic              out_psel,
    output logic              out_penable,
    output logic [2:0]        out_pprot,
    output logic [ADDR_W-1:0] out_paddr,
    output logic              out_pwrite,
    output logic [31:0]       out_pwdata,
    output logic [3:0]        out_pstrb,
    input  logic              out_pready,
    input  logic              out_pslverr,
    input  logic [31:0]       out_prdata
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    // Counter value seen on the last ACCESS cycle allowed before abort.
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q, psel_q, penable_q, resp_valid_q;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic [3:0]        pstrb_q, pstrb_d;
    logic [2:0]        pprot_q, pprot_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        pprot_d  = pprot_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    pstrb_d  = req_write ? req_wstrb : 4'b0000;
                    pprot_d  = req_prot;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (out_pready) begin
                    // A completing slave beats a timeout landing on the same cycle.
                    rdata_d = pwrite_q ? 32'h0 : out_prdata;
                    err_d   = out_pslverr;
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        tmo_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake/strobe outputs are registered decodes of the next state so
    // every output changes only on a clock edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= 32'h0;
            pstrb_q      <= 4'b0000;
            pprot_q      <= 3'b000;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= (state_d == S_IDLE);
            psel_q       <= (state_d == S_SETUP) || (state_d == S_ACCESS);
            penable_q    <= (state_d == S_ACCESS);
            resp_valid_q <= (state_d == S_RESP);
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            pprot_q      <= pprot_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = rdata_q;
    assign resp_err     = err_q;
    assign resp_timeout = tmo_q;
    assign out_psel     = psel_q;
    assign out_penable  = penable_q;
    assign out_pprot    = pprot_q;
    assign out_paddr    = paddr_q;
    assign out_pwrite   = pwrite_q;
    assign out_pwdata   = pwdata_q;
    assign out_pstrb    = pstrb_q;

endmodule
